// File: rtl/fpu_cmd_sequencer.sv
// Command sequencer for an FPU. It gathers a 9-byte command (op, data_1, data_2)
// from a byte stream, issues it once, waits for the result and streams it back as 4 bytes.
module fpu_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] fpu_data_1,
    output logic [31:0] fpu_data_2,
    output logic        fpu_op,
    output logic        fpu_valid,
    input  logic [31:0] fpu_result,
    input  logic        fpu_result_valid,
    output logic [7:0]  m_byte,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        o_busy,
    output logic        o_timeout
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RX,
        ST_ISSUE,
        ST_WAIT,
        ST_TX
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        byte_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        tx_cnt;
    logic              cmd_op;
    logic [31:0]       cmd_d1;
    logic [23:0]       cmd_d2;
    logic [31:0]       result;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_RX;
        end else begin
            state <= next_state;
        end
    end

    // The result wins over an expiring timeout, so it is tested first in WAIT.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        fpu_valid  = 1'b0;
        m_valid    = 1'b0;
        o_busy     = 1'b1;
        o_timeout  = 1'b0;
        case (state)
            ST_RX: begin
                s_ready = 1'b1;
                o_busy  = 1'b0;
                if (s_valid && (byte_cnt == 4'd8)) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_valid  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_result_valid) begin
                    next_state = ST_TX;
                end else if (wait_cnt == WAIT_LAST) begin
                    o_timeout  = 1'b1;
                    next_state = ST_RX;
                end
            end
            ST_TX: begin
                m_valid = 1'b1;
                if (m_ready && (tx_cnt == 2'd3)) begin
                    next_state = ST_RX;
                end
            end
            default: next_state = ST_RX;
        endcase
    end

    always_comb begin
        m_byte = 8'h00;
        case (tx_cnt)
            2'd0:    m_byte = result[31:24];
            2'd1:    m_byte = result[23:16];
            2'd2:    m_byte = result[15:8];
            default: m_byte = result[7:0];
        endcase
    end

    // Operands are assembled in shadow registers and only committed on the final
    // byte, so the FPU-facing values never show a half-received command.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            byte_cnt   <= 4'd0;
            wait_cnt   <= '0;
            tx_cnt     <= 2'd0;
            cmd_op     <= 1'b0;
            cmd_d1     <= 32'h0;
            cmd_d2     <= 24'h0;
            fpu_op     <= 1'b0;
            fpu_data_1 <= 32'h0;
            fpu_data_2 <= 32'h0;
            result     <= 32'h0;
        end else begin
            case (state)
                ST_RX: begin
                    if (s_valid) begin
                        if (byte_cnt == 4'd0) begin
                            cmd_op <= s_byte[0];
                        end else if (byte_cnt <= 4'd4) begin
                            cmd_d1 <= {cmd_d1[23:0], s_byte};
                        end else if (byte_cnt <= 4'd7) begin
                            cmd_d2 <= {cmd_d2[15:0], s_byte};
                        end else begin
                            fpu_op     <= cmd_op;
                            fpu_data_1 <= cmd_d1;
                            fpu_data_2 <= {cmd_d2, s_byte};
                        end
                        byte_cnt <= (byte_cnt == 4'd8) ? 4'd0 : byte_cnt + 4'd1;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    tx_cnt   <= 2'd0;
                end
                ST_WAIT: begin
                    if (fpu_result_valid) begin
                        result <= fpu_result;
                    end else if (wait_cnt == WAIT_LAST) begin
                        byte_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_TX: begin
                    if (m_ready) begin
                        tx_cnt <= tx_cnt + 2'd1;
                    end
                end
                default: byte_cnt <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed bench for fpu_cmd_sequencer: a per-cycle vector table for the basic command,
// then hand-written sequences for backpressure, timeout, race, reset and stray inputs.
module tb_fpu_cmd_sequencer;

    localparam int TIMEOUT = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  s_byte = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] fpu_data_1;
    logic [31:0] fpu_data_2;
    logic        fpu_op;
    logic        fpu_valid;
    logic [31:0] fpu_result = 32'h0;
    logic        fpu_result_valid = 1'b0;
    logic [7:0]  m_byte;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        o_busy;
    logic        o_timeout;

    int n_compared = 0;
    int n_failed = 0;

    fpu_cmd_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s_byte(s_byte), .s_valid(s_valid), .s_ready(s_ready),
        .fpu_data_1(fpu_data_1), .fpu_data_2(fpu_data_2), .fpu_op(fpu_op), .fpu_valid(fpu_valid),
        .fpu_result(fpu_result), .fpu_result_valid(fpu_result_valid),
        .m_byte(m_byte), .m_valid(m_valid), .m_ready(m_ready),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        sv;
        logic [7:0]  sb;
        logic        frv;
        logic [31:0] fr;
        logic        mr;
        logic        e_sready;
        logic        e_fvalid;
        logic        e_mvalid;
        logic [7:0]  e_mbyte;
        logic        e_busy;
        logic        e_tout;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic sv, input logic [7:0] sb, input logic frv,
                                input logic [31:0] fr, input logic mr, input logic esr,
                                input logic efv, input logic emv, input logic [7:0] emb,
                                input logic ebusy, input logic eto);
        vec_t v;
        v.sv = sv; v.sb = sb; v.frv = frv; v.fr = fr; v.mr = mr;
        v.e_sready = esr; v.e_fvalid = efv; v.e_mvalid = emv; v.e_mbyte = emb;
        v.e_busy = ebusy; v.e_tout = eto;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        s_valid = v.sv;
        s_byte = v.sb;
        fpu_result_valid = v.frv;
        fpu_result = v.fr;
        m_ready = v.mr;
        #1;
        check_output($sformatf("vec%0d s_ready", idx), s_ready, v.e_sready);
        check_output($sformatf("vec%0d fpu_valid", idx), fpu_valid, v.e_fvalid);
        check_output($sformatf("vec%0d m_valid", idx), m_valid, v.e_mvalid);
        check_output($sformatf("vec%0d o_busy", idx), o_busy, v.e_busy);
        check_output($sformatf("vec%0d o_timeout", idx), o_timeout, v.e_tout);
        if (v.e_mvalid) check_output($sformatf("vec%0d m_byte", idx), m_byte, v.e_mbyte);
        tick();
    endtask

    // Sends the first nbytes of a command; each byte waits (bounded) for s_ready.
    task automatic send_cmd(input logic [7:0] op, input logic [31:0] d1, input logic [31:0] d2,
                            input int nbytes);
        logic [31:0] tmp;
        for (int i = 0; i < nbytes; i++) begin
            if (i == 0) s_byte = op;
            else if (i <= 4) begin tmp = d1 >> (8 * (4 - i)); s_byte = tmp[7:0]; end
            else begin tmp = d2 >> (8 * (8 - i)); s_byte = tmp[7:0]; end
            s_valid = 1'b1;
            for (int n = 0; n < 20 && !s_ready; n++) tick();
            if (!s_ready) check_output($sformatf("send byte%0d s_ready", i), s_ready, 1'b1);
            tick();
        end
        s_valid = 1'b0;
        s_byte = 8'h00;
    endtask

    // Collects 4 TX bytes; with toggle set, m_ready alternates 0/1 starting at 0.
    task automatic collect_tx(input logic [31:0] exp, input logic toggle, input string name);
        logic [7:0]  got[4];
        logic [31:0] tmp;
        logic        prev_hold;
        logic [7:0]  prev_byte;
        logic        mr;
        int          n;
        got = '{8'h00, 8'h00, 8'h00, 8'h00};
        prev_hold = 1'b0;
        prev_byte = 8'h00;
        mr = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            m_ready = toggle ? mr : 1'b1;
            #1;
            if (prev_hold) begin
                check_output({name, " held m_valid"}, m_valid, 1'b1);
                check_output({name, " held m_byte"}, m_byte, prev_byte);
            end
            if (o_timeout) check_output({name, " o_timeout in TX"}, o_timeout, 1'b0);
            if (m_valid && m_ready) begin
                got[n] = m_byte;
                n++;
            end
            prev_hold = m_valid && !m_ready;
            prev_byte = m_byte;
            mr = ~mr;
            tick();
        end
        m_ready = 1'b0;
        check_output({name, " transfer count"}, n, 4);
        for (int i = 0; i < 4; i++) begin
            tmp = exp >> (24 - 8 * i);
            check_output($sformatf("%s byte%0d", name, i), got[i], tmp[7:0]);
        end
        check_output({name, " m_valid after last"}, m_valid, 1'b0);
        check_output({name, " s_ready after last"}, s_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] cmd_bytes[9];
        logic [7:0] tx_bytes[4];
        int         to_cnt;
        int         to_at;
        logic       mv_seen;

        cmd_bytes = '{8'h00, 8'h41, 8'h80, 8'h40, 8'h00, 8'hC2, 8'hA8, 8'hA0, 8'h00};
        tx_bytes = '{8'hC2, 8'h88, 8'h90, 8'h00};
        for (int i = 0; i < 9; i++) vecs[i] = mk(1, cmd_bytes[i], 0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        vecs[12] = mk(0, 0, 1, 32'hC2889000, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) vecs[13 + i] = mk(0, 0, 0, 0, 1, 0, 0, 1, tx_bytes[i], 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        $display("[TB] reset");
        tick();
        tick();
        i_rst_n = 1'b1;
        check_output("reset s_ready", s_ready, 1'b1);
        check_output("reset o_busy", o_busy, 1'b0);
        check_output("reset fpu_valid", fpu_valid, 1'b0);
        check_output("reset m_valid", m_valid, 1'b0);
        check_output("reset m_byte", m_byte, 8'h00);
        check_output("reset o_timeout", o_timeout, 1'b0);
        check_output("reset fpu_data_1", fpu_data_1, 32'h0);
        check_output("reset fpu_data_2", fpu_data_2, 32'h0);
        check_output("reset fpu_op", fpu_op, 1'b0);

        $display("[TB] basic command table");
        for (int i = 0; i < 18; i++) apply_stimulus(vecs[i], i);
        m_ready = 1'b0;
        check_output("basic fpu_data_1", fpu_data_1, 32'h41804000);
        check_output("basic fpu_data_2", fpu_data_2, 32'hC2A8A000);
        check_output("basic fpu_op", fpu_op, 1'b0);

        $display("[TB] backpressure");
        send_cmd(8'h01, 32'h3F800000, 32'h40000000, 9);
        check_output("bp issue fpu_valid", fpu_valid, 1'b1);
        check_output("bp fpu_op", fpu_op, 1'b1);
        tick();
        check_output("bp fpu_valid one cycle", fpu_valid, 1'b0);
        fpu_result_valid = 1'b1;
        fpu_result = 32'h12345678;
        tick();
        fpu_result_valid = 1'b0;
        collect_tx(32'h12345678, 1'b1, "bp");

        $display("[TB] timeout");
        send_cmd(8'h00, 32'h00000001, 32'h00000002, 9);
        check_output("to issue fpu_valid", fpu_valid, 1'b1);
        to_cnt = 0;
        to_at = -1;
        mv_seen = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (o_timeout) begin
                to_cnt++;
                if (to_at < 0) to_at = t;
            end
            if (m_valid) mv_seen = 1'b1;
            if (t == 9) check_output("to s_ready after expiry", s_ready, 1'b1);
        end
        check_output("to pulse count", to_cnt, 1);
        check_output("to pulse cycle", to_at, 8);
        check_output("to m_valid never", mv_seen, 1'b0);
        check_output("to o_busy idle", o_busy, 1'b0);

        $display("[TB] result/timeout race");
        send_cmd(8'h00, 32'h40000000, 32'h3F000000, 9);
        check_output("race issue fpu_valid", fpu_valid, 1'b1);
        for (int t = 1; t <= 8; t++) tick();
        fpu_result_valid = 1'b1;
        fpu_result = 32'h3F800000;
        #1;
        check_output("race no o_timeout", o_timeout, 1'b0);
        tick();
        fpu_result_valid = 1'b0;
        collect_tx(32'h3F800000, 1'b0, "race");

        $display("[TB] reset mid-command");
        send_cmd(8'h00, 32'h11223344, 32'h55667788, 5);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check_output("rst s_ready", s_ready, 1'b1);
        check_output("rst o_busy", o_busy, 1'b0);
        send_cmd(8'hFF, 32'hAABBCCDD, 32'h01020304, 9);
        check_output("rst new fpu_valid", fpu_valid, 1'b1);
        check_output("rst new fpu_op", fpu_op, 1'b1);
        check_output("rst new fpu_data_1", fpu_data_1, 32'hAABBCCDD);
        check_output("rst new fpu_data_2", fpu_data_2, 32'h01020304);
        tick();
        fpu_result_valid = 1'b1;
        fpu_result = 32'h87654321;
        tick();
        fpu_result_valid = 1'b0;
        m_ready = 1'b0;
        check_output("rst tx m_valid", m_valid, 1'b1);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check_output("rst in tx m_valid", m_valid, 1'b0);
        check_output("rst in tx m_byte", m_byte, 8'h00);
        check_output("rst in tx o_busy", o_busy, 1'b0);
        check_output("rst in tx fpu_data_1", fpu_data_1, 32'h0);
        tick();
        tick();
        check_output("rst no late m_valid", m_valid, 1'b0);
        check_output("rst no late fpu_valid", fpu_valid, 1'b0);

        $display("[TB] stray and blocked inputs");
        fpu_result_valid = 1'b1;
        fpu_result = 32'hDEADBEEF;
        tick();
        fpu_result_valid = 1'b0;
        check_output("stray frv o_busy", o_busy, 1'b0);
        check_output("stray frv m_valid", m_valid, 1'b0);
        send_cmd(8'h01, 32'hCAFEF00D, 32'h0BADBEEF, 9);
        check_output("stray issue fpu_valid", fpu_valid, 1'b1);
        tick();
        s_valid = 1'b1;
        s_byte = 8'h55;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("stray wait s_ready %0d", i), s_ready, 1'b0);
            tick();
        end
        s_valid = 1'b0;
        s_byte = 8'h00;
        fpu_result_valid = 1'b1;
        fpu_result = 32'h0000ABCD;
        tick();
        fpu_result_valid = 1'b0;
        collect_tx(32'h0000ABCD, 1'b1, "stray");
        send_cmd(8'h00, 32'h40490FDB, 32'hBF800000, 9);
        check_output("after stray fpu_valid", fpu_valid, 1'b1);
        check_output("after stray fpu_op", fpu_op, 1'b0);
        check_output("after stray fpu_data_1", fpu_data_1, 32'h40490FDB);
        check_output("after stray fpu_data_2", fpu_data_2, 32'hBF800000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/fpu_cmd_sequencer.md
FPU_CMD_SEQUENCER -- requirements
Module: fpu_cmd_sequencer

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 64, the maximum number of WAIT cycles for an FPU result.
REQ-002 i_clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  in  1  reset; synchronous and active-low.
REQ-004 s_byte  in  8  inbound command byte.
REQ-005 s_valid  in  1  s_byte valid.
REQ-006 s_ready  out  1  the block accepts s_byte.
REQ-007 fpu_data_1  out  32  operand 1 to the FPU.
REQ-008 fpu_data_2  out  32  operand 2 to the FPU.
REQ-009 fpu_op  out  1  operation select to the FPU.
REQ-010 fpu_valid  out  1  one-cycle issue strobe to the FPU.
REQ-011 fpu_result  in  32  FPU result.
REQ-012 fpu_result_valid  in  1  fpu_result valid.
REQ-013 m_byte  out  8  outbound result byte.
REQ-014 m_valid  out  1  m_byte valid.
REQ-015 m_ready  in  1  the downstream accepts m_byte.
REQ-016 o_busy  out  1  high in any state other than RX.
REQ-017 o_timeout  out  1  one-cycle pulse when a result wait expires.

Function
REQ-018 States SHALL be RX, ISSUE, WAIT and TX, with a byte counter of 0..8 and a wait counter sized for TIMEOUT_CYCLES.
REQ-019 Byte transfers SHALL occur only on a rising edge with valid and ready both high.
REQ-020 In RX, s_ready SHALL be 1; in every other state, s_ready SHALL be 0.
REQ-021 An RX command SHALL be 9 bytes in this order:
- byte 0: op; fpu_op is taken from bit 0, bits 7:1 are ignored.
- bytes 1-4: data_1, MSB first.
- bytes 5-8: data_2, MSB first.
REQ-022 fpu_data_1, fpu_data_2 and fpu_op SHALL be registered and SHALL hold their values from the end of command capture until the next command overwrites them.
REQ-023 Accepting byte 8 SHALL move RX to ISSUE; in ISSUE, fpu_valid SHALL be 1 for exactly one cycle, i.e. the cycle after byte 8 is accepted.
REQ-024 ISSUE SHALL always move to WAIT and clear the wait counter.
REQ-025 In WAIT, on fpu_result_valid=1, the block SHALL capture fpu_result and move to TX.
REQ-026 In WAIT, when the wait counter reaches TIMEOUT_CYCLES-1 without fpu_result_valid, the block SHALL pulse o_timeout for one cycle, drop the command and return to RX with the byte counter at 0.
REQ-027 If fpu_result_valid is 1 in the same cycle the timeout expires, the result SHALL win: capture and TX, with no o_timeout pulse.
REQ-028 fpu_result_valid outside WAIT SHALL be ignored.
REQ-029 In TX, the block SHALL present the captured result as 4 bytes, MSB first; m_valid SHALL rise in the first cycle after capture.
REQ-030 While m_valid=1 and m_ready=0, m_byte SHALL be held stable.
REQ-031 After byte 3 is accepted, the block SHALL return to RX; m_valid SHALL be 0 in the following cycle.
REQ-032 s_valid during a non-RX state SHALL not be consumed; the upstream holds the byte.
REQ-033 The block SHALL have no internal queue: one command is outstanding at most.

Reset
REQ-034 When i_rst_n=0 at a rising edge, the following SHALL be cleared to 0 in the same edge, from any state including mid-command, WAIT and TX:
- state to RX, byte and wait counters
- s_ready (reads 1 in RX after reset)
- fpu_data_1, fpu_data_2, fpu_op, fpu_valid
- m_byte, m_valid, o_busy, o_timeout
REQ-035 A partially received command or pending result SHALL be discarded by reset; no fpu_valid or m_valid SHALL follow from it.

Verification
REQ-036 Basic command: send 00 41 80 40 00 C2 A8 A0 00, then the FPU model returns C2889000 3 cycles after fpu_valid -> fpu_data_1=41804000, fpu_data_2=C2A8A000, fpu_op=0; fpu_valid high exactly 1 cycle, the cycle after byte 8; m_byte sequence C2 88 90 00.
REQ-037 Backpressure: m_ready toggles 0/1 every cycle during TX -> each byte held stable while unaccepted; exactly 4 transfers; no duplicates or drops.
REQ-038 Timeout: TIMEOUT_CYCLES=8, FPU model never responds -> o_timeout pulses once, 8 cycles after ISSUE; state returns to RX; s_ready=1; m_valid never asserted.
REQ-039 Race: fpu_result_valid asserted in the exact expiry cycle with result 3F800000 -> no o_timeout; m_byte sequence 3F 80 00 00.
REQ-040 Reset mid-command: i_rst_n=0 after 5 bytes, then a full new command with op byte FF -> first 5 bytes discarded; fpu_op=1; the new operands are issued correctly.
REQ-041 Stray and blocked inputs: fpu_result_valid pulsed in RX, and s_valid held 1 during WAIT -> both are ignored; no byte is consumed until RX resumes.
